adbg_lint_arbiter: RTL and testbench
====================================

Name: adbg_lint_arbiter

Overview:
- Two-master arbiter sharing one LINT bus port between the debug BIU (master 0) and a second LINT requester (master 1), e.g. a second debug/DMA agent.
- Round-robin grant on the request channel, in-order tracking of outstanding transactions, and routing of each r_valid back to the master that issued it.
- Sits between the debug LINT masters and the SoC interconnect, in the clk_i domain.

Parameters:
- ADDR_WIDTH, 32: LINT address width.
- DATA_WIDTH, 64: LINT data width; byte enable width is DATA_WIDTH/8.
- AUX_WIDTH, 6: request aux field width.
- MAX_OUTSTANDING, 4: depth of the owner-ID FIFO. Must be a power of 2 and at least 1.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- m0_req_i / m1_req_i  in  1  master request.
- m0_add_i / m1_add_i  in  ADDR_WIDTH  address.
- m0_wen_i / m1_wen_i  in  1  write-enable-n (1 = read).
- m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data.
- m0_be_i / m1_be_i  in  DATA_WIDTH/8  byte enables.
- m0_aux_i / m1_aux_i  in  AUX_WIDTH  aux.
- m0_gnt_o / m1_gnt_o  out  1  grant to master.
- m0_r_valid_o / m1_r_valid_o  out  1  response valid to master.
- m_r_rdata_o  out  DATA_WIDTH  response data, broadcast to both masters.
- m_r_aux_o  out  1  response aux, broadcast.
- m_r_opc_o  out  1  response error/opcode, broadcast.
- lint_req_o  out  1  bus request.
- lint_add_o  out  ADDR_WIDTH  bus address.
- lint_wen_o  out  1  bus write-enable-n.
- lint_wdata_o  out  DATA_WIDTH  bus write data.
- lint_be_o  out  DATA_WIDTH/8  bus byte enables.
- lint_aux_o  out  AUX_WIDTH  bus aux.
- lint_gnt_i  in  1  bus grant.
- lint_r_valid_i  in  1  bus response valid.
- lint_r_rdata_i  in  DATA_WIDTH  bus response data.
- lint_r_aux_i  in  1  bus response aux.
- lint_r_opc_i  in  1  bus response opc.
- unexp_rsp_o  out  1  one-cycle pulse: response arrived with no outstanding transaction.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count.

Behaviour:
- Registered state:
  - rr_q (preferred master), reset 0.
  - Owner FIFO: MAX_OUTSTANDING entries × 1 bit, wr/rd pointers, count; all reset 0.
  - unexp_rsp_o register, reset 0.
- Winner selection (combinational):
  - Only one master requesting: that master wins.
  - Both requesting: rr_q wins.
  - Neither requesting: no winner.
- full = (count == MAX_OUTSTANDING). It is based on registered count only; no same-cycle pop bypass.
- Request channel:
  - lint_req_o = winner exists && !full.
  - add/wen/wdata/be/aux are muxed from the winner. When lint_req_o = 0, they are driven to 0 and wen to 1.
- Grant:
  - mX_gnt_o = lint_gnt_i && lint_req_o && winner==X.
  - Non-winner gnt is always 0.
  - While full, both mX_gnt_o = 0 whatever lint_gnt_i is.
- Handshake (lint_req_o && lint_gnt_i):
  - Push winner ID into the FIFO.
  - rr_q <= ~winner, i.e. the loser of the cycle gets priority next.
  - No handshake: rr_q holds.
- Request stability: masters hold req and payload until granted. The arbiter may switch winner only between handshakes. A master that drops req before gnt is simply not selected; no error.
- Response channel:
  - On lint_r_valid_i with count>0: pop the FIFO head; m{head}_r_valid_o = 1 in the same cycle (combinational); the other master's r_valid = 0.
  - rdata/aux/opc pass through combinationally.
- Response latency: responses are in order and arrive at least one cycle after their grant. A same-cycle response is never matched to that cycle's push.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: modulo MAX_OUTSTANDING.
- Unexpected response (lint_r_valid_i with count==0):
  - Both r_valid_o = 0; FIFO untouched.
  - unexp_rsp_o = 1 on the next cycle for one cycle.
- Reset asserted mid-operation:
  - FIFO cleared, rr_q = 0, all outputs return to their idle values immediately.
  - Responses in flight at reset are then treated as unexpected after reset release.
- Reset values:
  - lint_req_o, all gnt/r_valid, unexp_rsp_o, outstanding_o = 0.
  - lint_wen_o = 1; other payload outputs = 0.

Decomposition:
- No shared package needed.
- One sub-module: adbg_lint_arb_fifo, a synchronous 1-bit-wide FIFO with parameter DEPTH, ports push/pop/din/dout/full/empty/count, async active-low reset.

Test Plan:
- Only m0 requests, add=0x1000_0000, wen=1, lint_gnt_i=1 → m0_gnt_o=1, lint_add_o=0x1000_0000. Response 2 cycles later with rdata=0xDEAD_BEEF_0123_4567 → m0_r_valid_o=1, m1_r_valid_o=0.
- Both request continuously, lint_gnt_i=1, responses held off → grants alternate m0,m1,m0,m1. After 4 grants, outstanding_o=4 and lint_req_o=0; m0_gnt_o=m1_gnt_o=0 even with lint_gnt_i=1.
- From the full state, issue 4 responses → r_valid routed in order m0,m1,m0,m1; lint_req_o reasserts on the cycle after the first pop.
- One handshake and one response in the same cycle, count=2 → count stays 2; the response is routed to the oldest owner.
- lint_r_valid_i with count=0 → no mX_r_valid_o; unexp_rsp_o pulses high one cycle later.
- rstn_i low while count=3 → count=0, rr_q=0, lint_req_o=0 asynchronously. After release, a lone m1 request is granted normally.

Source files
------------

// File: rtl/adbg_lint_arbiter_pkg.sv
// rtl/adbg_lint_arbiter_pkg.sv - shared types for the two-master LINT arbiter
package adbg_lint_arbiter_pkg;

  // Identity of a LINT master; also the value stored in the owner FIFO.
  typedef enum logic {
    MST_0 = 1'b0,
    MST_1 = 1'b1
  } mst_id_e;

  // The master that did not win; it gets priority after a handshake.
  function automatic mst_id_e other_mst(input mst_id_e id);
    return (id == MST_0) ? MST_1 : MST_0;
  endfunction

endpackage

// File: rtl/adbg_lint_arbiter_if.sv
// rtl/adbg_lint_arbiter_if.sv - LINT bus port bundle with master/slave views
interface adbg_lint_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int AUX_WIDTH  = 6
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [AUX_WIDTH-1:0]    aux;
  logic                    gnt;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_aux;
  logic                    r_opc;

  // Request issuer: drives the request channel, receives grant and response.
  modport master (
    output req, add, wen, wdata, be, aux,
    input  gnt, r_valid, r_rdata, r_aux, r_opc
  );

  // Bus target: accepts requests, returns grant and response.
  modport slave (
    input  req, add, wen, wdata, be, aux,
    output gnt, r_valid, r_rdata, r_aux, r_opc
  );
endinterface

// File: rtl/adbg_lint_arb_fifo.sv
// rtl/adbg_lint_arb_fifo.sv - 1-bit owner-ID FIFO tracking outstanding LINT transactions
module adbg_lint_arb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     din_i,
  output logic                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so non-power-of-two widths of the index stay safe.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // Guard against overflow/underflow; the empty check also keeps a same-cycle
  // push from being popped before it is stored.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_inc(rd_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adbg_lint_arbiter.sv
// rtl/adbg_lint_arbiter.sv - round-robin arbiter of two LINT masters onto one bus port
module adbg_lint_arbiter
  import adbg_lint_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int AUX_WIDTH       = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               m0_req_i,
  input  logic [ADDR_WIDTH-1:0]              m0_add_i,
  input  logic                               m0_wen_i,
  input  logic [DATA_WIDTH-1:0]              m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            m0_be_i,
  input  logic [AUX_WIDTH-1:0]               m0_aux_i,
  input  logic                               m1_req_i,
  input  logic [ADDR_WIDTH-1:0]              m1_add_i,
  input  logic                               m1_wen_i,
  input  logic [DATA_WIDTH-1:0]              m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            m1_be_i,
  input  logic [AUX_WIDTH-1:0]               m1_aux_i,
  output logic                               m0_gnt_o,
  output logic                               m1_gnt_o,
  output logic                               m0_r_valid_o,
  output logic                               m1_r_valid_o,
  output logic [DATA_WIDTH-1:0]              m_r_rdata_o,
  output logic                               m_r_aux_o,
  output logic                               m_r_opc_o,
  output logic                               lint_req_o,
  output logic [ADDR_WIDTH-1:0]              lint_add_o,
  output logic                               lint_wen_o,
  output logic [DATA_WIDTH-1:0]              lint_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            lint_be_o,
  output logic [AUX_WIDTH-1:0]               lint_aux_o,
  input  logic                               lint_gnt_i,
  input  logic                               lint_r_valid_i,
  input  logic [DATA_WIDTH-1:0]              lint_r_rdata_i,
  input  logic                               lint_r_aux_i,
  input  logic                               lint_r_opc_i,
  output logic                               unexp_rsp_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

  mst_id_e rr_q, rr_d;
  logic    unexp_q, unexp_d;
  mst_id_e winner;
  logic    winner_vld;
  logic    handshake;
  logic    rsp_pop;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_head;

  // Pick the requesting master; on contention the preferred one wins.
  always_comb begin
    winner_vld = m0_req_i || m1_req_i;
    if (m0_req_i && m1_req_i) winner = rr_q;
    else if (m1_req_i)        winner = MST_1;
    else                      winner = MST_0;
  end

  // Request channel: forward the winner's payload, idle pattern otherwise.
  // Gating with rstn_i keeps the bus idle for the whole reset window even if
  // masters keep requesting.
  always_comb begin
    lint_req_o   = rstn_i && winner_vld && !fifo_full;
    lint_add_o   = '0;
    lint_wen_o   = 1'b1;
    lint_wdata_o = '0;
    lint_be_o    = '0;
    lint_aux_o   = '0;
    if (lint_req_o) begin
      if (winner == MST_1) begin
        lint_add_o   = m1_add_i;
        lint_wen_o   = m1_wen_i;
        lint_wdata_o = m1_wdata_i;
        lint_be_o    = m1_be_i;
        lint_aux_o   = m1_aux_i;
      end else begin
        lint_add_o   = m0_add_i;
        lint_wen_o   = m0_wen_i;
        lint_wdata_o = m0_wdata_i;
        lint_be_o    = m0_be_i;
        lint_aux_o   = m0_aux_i;
      end
    end
  end

  // Grant goes only to the winner, and only when the request is really issued.
  always_comb begin
    handshake = lint_req_o && lint_gnt_i;
    m0_gnt_o  = handshake && (winner == MST_0);
    m1_gnt_o  = handshake && (winner == MST_1);
  end

  // Response routing: the oldest owner ID receives r_valid; data is broadcast.
  always_comb begin
    rsp_pop      = rstn_i && lint_r_valid_i && !fifo_empty;
    m0_r_valid_o = rsp_pop && (fifo_head == MST_0);
    m1_r_valid_o = rsp_pop && (fifo_head == MST_1);
    m_r_rdata_o  = lint_r_rdata_i;
    m_r_aux_o    = lint_r_aux_i;
    m_r_opc_o    = lint_r_opc_i;
  end

  // Next-state for priority pointer and the unexpected-response flag.
  always_comb begin
    rr_d    = handshake ? other_mst(winner) : rr_q;
    unexp_d = lint_r_valid_i && fifo_empty;
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q    <= MST_0;
      unexp_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      unexp_q <= unexp_d;
    end
  end

  assign unexp_rsp_o = unexp_q;

  adbg_lint_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (handshake),
    .pop_i   (rsp_pop),
    .din_i   (winner == MST_1),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_adbg_lint_arbiter.sv
// tb/tb_adbg_lint_arbiter.sv - directed self-checking bench for adbg_lint_arbiter
module tb_adbg_lint_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int XW = 6;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_add, m1_add;
  logic          m0_wen, m1_wen;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_be, m1_be;
  logic [XW-1:0] m0_aux, m1_aux;
  logic          m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [DW-1:0] r_rdata;
  logic          r_aux, r_opc, unexp;
  logic [2:0]    outst;

  int checks = 0;
  int failures = 0;

  adbg_lint_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUX_WIDTH(XW)) bus ();

  always #5 clk = ~clk;

  adbg_lint_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUX_WIDTH(XW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m0_req_i(m0_req), .m0_add_i(m0_add), .m0_wen_i(m0_wen), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_aux_i(m0_aux),
    .m1_req_i(m1_req), .m1_add_i(m1_add), .m1_wen_i(m1_wen), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_aux_i(m1_aux),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_r_valid_o(m0_rv), .m1_r_valid_o(m1_rv),
    .m_r_rdata_o(r_rdata), .m_r_aux_o(r_aux), .m_r_opc_o(r_opc),
    .lint_req_o(bus.req), .lint_add_o(bus.add), .lint_wen_o(bus.wen),
    .lint_wdata_o(bus.wdata), .lint_be_o(bus.be), .lint_aux_o(bus.aux),
    .lint_gnt_i(bus.gnt), .lint_r_valid_i(bus.r_valid), .lint_r_rdata_i(bus.r_rdata),
    .lint_r_aux_i(bus.r_aux), .lint_r_opc_i(bus.r_opc),
    .unexp_rsp_o(unexp), .outstanding_o(outst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_req = 0; m1_req = 0;
    m0_add = 32'h1000_0000; m1_add = 32'h2000_0040;
    m0_wen = 1; m1_wen = 0;
    m0_wdata = 64'h0; m1_wdata = 64'h1111_2222_3333_4444;
    m0_be = 8'hFF; m1_be = 8'h0F;
    m0_aux = 6'h05; m1_aux = 6'h2A;
    bus.gnt = 0; bus.r_valid = 0; bus.r_rdata = '0; bus.r_aux = 0; bus.r_opc = 0;

    // Reset values
    #2;
    chk("rst_req", bus.req, 0);
    chk("rst_wen", bus.wen, 1);
    chk("rst_add", bus.add, 0);
    chk("rst_outst", outst, 0);
    chk("rst_unexp", unexp, 0);
    step(); step();
    rstn = 1;

    // Lone m0 read, response two cycles later
    m0_req = 1; bus.gnt = 1;
    #1;
    chk("t1_req", bus.req, 1);
    chk("t1_m0_gnt", m0_gnt, 1);
    chk("t1_m1_gnt", m1_gnt, 0);
    chk("t1_add", bus.add, 32'h1000_0000);
    chk("t1_aux", bus.aux, 6'h05);
    step();
    m0_req = 0; bus.gnt = 0;
    chk("t1_outst", outst, 1);
    step();
    bus.r_valid = 1; bus.r_rdata = 64'hDEAD_BEEF_0123_4567; bus.r_opc = 1;
    #1;
    chk("t1_m0_rv", m0_rv, 1);
    chk("t1_m1_rv", m1_rv, 0);
    chk("t1_rdata", r_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t1_opc", r_opc, 1);
    step();
    bus.r_valid = 0; bus.r_opc = 0;
    chk("t1_outst0", outst, 0);
    chk("t1_unexp", unexp, 0);

    // Fresh reset so priority starts at m0 again
    rstn = 0; step(); rstn = 1;

    // Both request, grants alternate until full
    m0_req = 1; m1_req = 1; bus.gnt = 1;
    #1;
    chk("t2_g0_m0", m0_gnt, 1); chk("t2_g0_m1", m1_gnt, 0);
    chk("t2_g0_add", bus.add, 32'h1000_0000);
    step();
    chk("t2_g1_m0", m0_gnt, 0); chk("t2_g1_m1", m1_gnt, 1);
    chk("t2_g1_add", bus.add, 32'h2000_0040);
    chk("t2_g1_wen", bus.wen, 0);
    chk("t2_g1_be", bus.be, 8'h0F);
    step();
    chk("t2_g2_m0", m0_gnt, 1); chk("t2_g2_m1", m1_gnt, 0);
    step();
    chk("t2_g3_m0", m0_gnt, 0); chk("t2_g3_m1", m1_gnt, 1);
    step();
    chk("t2_full_outst", outst, 4);
    chk("t2_full_req", bus.req, 0);
    chk("t2_full_m0g", m0_gnt, 0);
    chk("t2_full_m1g", m1_gnt, 0);
    chk("t2_full_wen", bus.wen, 1);
    chk("t2_full_add", bus.add, 0);

    // Drain in order m0,m1,m0,m1 with requests still pending
    bus.gnt = 0; bus.r_valid = 1;
    #1;
    chk("t3_p0_m0", m0_rv, 1); chk("t3_p0_m1", m1_rv, 0);
    chk("t3_p0_req", bus.req, 0);
    step();
    chk("t3_p1_req", bus.req, 1);
    chk("t3_p1_outst", outst, 3);
    chk("t3_p1_m0", m0_rv, 0); chk("t3_p1_m1", m1_rv, 1);
    step();
    chk("t3_p2_m0", m0_rv, 1); chk("t3_p2_m1", m1_rv, 0);
    step();
    chk("t3_p3_m0", m0_rv, 0); chk("t3_p3_m1", m1_rv, 1);
    step();
    bus.r_valid = 0;
    chk("t3_outst0", outst, 0);

    // Two grants (m0 then m1) leave FIFO = [m0, m1]
    bus.gnt = 1;
    step(); step();
    chk("t4_outst2", outst, 2);
    // Push (winner m0) and pop same cycle: head is oldest owner m0
    bus.r_valid = 1;
    #1;
    chk("t4_push_m0g", m0_gnt, 1);
    chk("t4_pop_m0", m0_rv, 1); chk("t4_pop_m1", m1_rv, 0);
    step();
    m0_req = 0; m1_req = 0; bus.gnt = 0;
    chk("t4_outst_hold", outst, 2);
    chk("t4_d0_m1", m1_rv, 1); chk("t4_d0_m0", m0_rv, 0);
    step();
    chk("t4_d1_m0", m0_rv, 1); chk("t4_d1_m1", m1_rv, 0);
    step();
    chk("t4_outst0", outst, 0);

    // Response with nothing outstanding
    chk("t5_m0_rv", m0_rv, 0); chk("t5_m1_rv", m1_rv, 0);
    chk("t5_unexp_now", unexp, 0);
    step();
    bus.r_valid = 0;
    chk("t5_unexp_pulse", unexp, 1);
    chk("t5_outst", outst, 0);
    step();
    chk("t5_unexp_clear", unexp, 0);

    // Three m0 transactions (priority moves to m1), then async reset
    m0_req = 1; bus.gnt = 1;
    step(); step(); step();
    chk("t6_outst3", outst, 3);
    m1_req = 1; bus.gnt = 0;
    #2;
    rstn = 0;
    #1;
    chk("t6_rst_outst", outst, 0);
    chk("t6_rst_req", bus.req, 0);
    chk("t6_rst_wen", bus.wen, 1);
    step();
    rstn = 1;
    #1;
    chk("t6_rr0_add", bus.add, 32'h1000_0000);
    m0_req = 0; bus.gnt = 1;
    #1;
    chk("t6_m1_gnt", m1_gnt, 1);
    chk("t6_m1_add", bus.add, 32'h2000_0040);
    step();
    m1_req = 0; bus.gnt = 0;
    chk("t6_outst1", outst, 1);
    bus.r_valid = 1;
    #1;
    chk("t6_rsp_m1", m1_rv, 1);
    step();
    // Stale in-flight response from before reset
    chk("t6_stale_rv", m1_rv | m0_rv, 0);
    step();
    bus.r_valid = 0;
    chk("t6_stale_unexp", unexp, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
